// File: rtl/hi_lo_multiply_divide_unit.sv
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, then a sign fixup cycle.
module hi_lo_multiply_divide_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       operation_execute,
  input  logic [WIDTH-1:0] source_A_execute,
  input  logic [WIDTH-1:0] source_B_execute,
  input  logic             flush_execute_register,
  output logic             busy,
  output logic [WIDTH-1:0] HI_output,
  output logic [WIDTH-1:0] LO_output,
  output logic             done_pulse
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {IDLE, MULTIPLY, DIVIDE, FIXUP} state_t;

  state_t             state, next_state;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   multiplier;
  logic [CW-1:0]      count;
  logic               neg_result;
  logic               neg_rem;
  logic               is_div;

  logic               accept, start_mult, start_div, div_zero, last_step;
  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_take;
  logic [WIDTH-1:0]   div_rem, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;

  // Operations are only taken in IDLE, so anything presented while busy is dropped.
  assign accept     = (state == IDLE) && !flush_execute_register &&
                      (operation_execute inside {[OP_MULT:OP_MTLO]});
  assign start_mult = accept && (operation_execute inside {OP_MULT, OP_MULTU});
  assign start_div  = accept && (operation_execute inside {OP_DIV, OP_DIVU});
  assign div_zero   = (source_B_execute == '0);
  assign last_step  = (count == CW'(WIDTH - 1));

  assign signed_op = (operation_execute == OP_MULT) || (operation_execute == OP_DIV);
  assign a_neg     = signed_op && source_A_execute[WIDTH-1];
  assign b_neg     = signed_op && source_B_execute[WIDTH-1];
  assign a_mag     = a_neg ? -source_A_execute : source_A_execute;
  assign b_mag     = b_neg ? -source_B_execute : source_B_execute;

  // Multiply: add multiplicand into the upper half, shift the product right.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                   (multiplier[0] ? {1'b0, operand} : '0);

  // Divide: acc holds {remainder, dividend/quotient}; a negative difference restores.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, operand};
  assign div_take  = !div_diff[WIDTH];
  assign div_rem   = div_take ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];

  assign prod_fix = neg_result ? -acc : acc;
  assign quo_fix  = neg_result ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start_mult)     next_state = MULTIPLY;
        else if (start_div) next_state = div_zero ? FIXUP : DIVIDE;
      end
      MULTIPLY: if (last_step) next_state = FIXUP;
      DIVIDE:   if (last_step) next_state = FIXUP;
      FIXUP:    next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      operand    <= '0;
      multiplier <= '0;
      count      <= '0;
      neg_result <= 1'b0;
      neg_rem    <= 1'b0;
      is_div     <= 1'b0;
      HI_output  <= '0;
      LO_output  <= '0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            count <= '0;
            case (operation_execute)
              OP_MTHI: HI_output <= source_A_execute;
              OP_MTLO: LO_output <= source_A_execute;
              OP_MULT, OP_MULTU: begin
                operand    <= a_mag;
                multiplier <= b_mag;
                acc        <= '0;
                neg_result <= a_neg ^ b_neg;
                neg_rem    <= 1'b0;
                is_div     <= 1'b0;
              end
              default: begin
                operand <= b_mag;
                is_div  <= 1'b1;
                if (div_zero) begin
                  // Divide by zero bypasses iteration; result is raw and unsigned.
                  acc        <= {source_A_execute, {WIDTH{1'b1}}};
                  neg_result <= 1'b0;
                  neg_rem    <= 1'b0;
                end else begin
                  acc        <= {{WIDTH{1'b0}}, a_mag};
                  neg_result <= a_neg ^ b_neg;
                  neg_rem    <= a_neg;
                end
              end
            endcase
          end
        end
        MULTIPLY: begin
          acc        <= {mul_sum, acc[WIDTH-1:1]};
          multiplier <= multiplier >> 1;
          count      <= count + CW'(1);
        end
        DIVIDE: begin
          acc   <= {div_rem, acc[WIDTH-2:0], div_take};
          count <= count + CW'(1);
        end
        FIXUP: begin
          if (is_div) begin
            HI_output <= rem_fix;
            LO_output <= quo_fix;
          end else begin
            HI_output <= prod_fix[2*WIDTH-1:WIDTH];
            LO_output <= prod_fix[WIDTH-1:0];
          end
          done_pulse <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hi_lo_multiply_divide_unit.sv
// Self-checking bench: expected {HI,LO} pushed at issue, popped and compared on done_pulse.
module tb_hi_lo_multiply_divide_unit;

  localparam int W = 32;
  localparam logic [2:0] MULT = 3'b001, MULTU = 3'b010, DIV = 3'b011, DIVU = 3'b100;
  localparam logic [2:0] MTHI = 3'b101, MTLO = 3'b110;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [2:0]   operation_execute = '0;
  logic [W-1:0] source_A_execute = '0;
  logic [W-1:0] source_B_execute = '0;
  logic         flush_execute_register = 1'b0;
  logic         busy, done_pulse;
  logic [W-1:0] HI_output, LO_output;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  hi_lo_multiply_divide_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .operation_execute(operation_execute),
    .source_A_execute(source_A_execute),
    .source_B_execute(source_B_execute),
    .flush_execute_register(flush_execute_register),
    .busy(busy),
    .HI_output(HI_output),
    .LO_output(LO_output),
    .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference arithmetic on 64-bit integers; returns {HI, LO}.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      MULT:  return 64'(sa * sb);
      MULTU: return ua * ub;
      DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  // Drives one op at a negedge and returns at the negedge after the accepting edge.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
    @(negedge clk);
    operation_execute = op;
    source_A_execute  = a;
    source_B_execute  = b;
    exp_q.push_back(exp);
    @(negedge clk);
    operation_execute = '0;
  endtask

  // Counts busy cycles from the current negedge until done_pulse, then scores the result.
  task automatic finish_op(input string tag, input int already, input int exp_busy);
    int n = already;
    bit seen = 0;
    logic [63:0] exp;
    for (int i = 0; i < 200; i++) begin
      if (done_pulse) begin
        seen = 1;
        break;
      end
      if (busy) n++;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    exp = exp_q.pop_front();
    if (seen) begin
      check({tag, "_hilo"}, {HI_output, LO_output}, exp);
      check({tag, "_busy_cycles"}, 64'(n), 64'(exp_busy));
      check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      @(negedge clk);
      check({tag, "_single_pulse"}, 64'(done_pulse), 64'd0);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int exp_busy);
    start_op(op, a, b, exp);
    finish_op(tag, 0, exp_busy);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic [31:0] hi_before;

    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hilo", {HI_output, LO_output}, 64'd0);
    check("reset_done", 64'(done_pulse), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("mult_neg3x5", MULT, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1}, W + 1);
    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, W + 1);
    run_op("divu_100_7", DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, W + 1);
    run_op("div_neg7_2", DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, W + 1);
    run_op("div_min_neg1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, W + 1);
    run_op("divu_by0", DIVU, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF}, 1);
    run_op("div_by0", DIV, 32'hFFFF_0000, 32'd0, {32'hFFFF_0000, 32'hFFFF_FFFF}, 1);

    for (int i = 0; i < 6; i++) begin
      rop = 3'(1 + (i % 4));
      ra  = $urandom;
      rb  = (i == 5) ? 32'($urandom_range(1, 300)) : $urandom;
      run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb), W + 1);
    end

    // MTHI squashed by flush, then accepted.
    hi_before = HI_output;
    @(negedge clk);
    operation_execute = MTHI; source_A_execute = 32'hAAAA_0000; flush_execute_register = 1'b1;
    @(negedge clk);
    check("mthi_flushed", 64'(HI_output), 64'(hi_before));
    check("mthi_flushed_busy", 64'(busy), 64'd0);
    flush_execute_register = 1'b0;
    @(negedge clk);
    operation_execute = '0;
    check("mthi_write", 64'(HI_output), 64'h0000_0000_AAAA_0000);
    check("mthi_busy", 64'(busy), 64'd0);
    @(negedge clk);
    operation_execute = MTLO; source_A_execute = 32'h5555_1234;
    @(negedge clk);
    operation_execute = '0;
    check("mtlo_write", {HI_output, LO_output}, {32'hAAAA_0000, 32'h5555_1234});

    // MTLO while multiplying must be ignored.
    start_op(MULT, 32'd3, 32'd5, {32'd0, 32'd15});
    operation_execute = MTLO; source_A_execute = 32'hDEAD_BEEF;
    @(negedge clk);
    operation_execute = '0;
    check("mtlo_while_busy", 64'(LO_output), 64'h0000_0000_5555_1234);
    finish_op("mult_after_mtlo", 1, W + 1);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    operation_execute = MULT; source_A_execute = 32'd1000; source_B_execute = 32'd1000;
    @(negedge clk);
    operation_execute = '0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_hilo", {HI_output, LO_output}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 64'(busy), 64'd0);
    run_op("mult_6x7", MULT, 32'd6, 32'd7, {32'd0, 32'd42}, W + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hi_lo_multiply_divide_unit.md
Name: hi_lo_multiply_divide_unit

Overview:
- Iterative multiply/divide unit in the execute stage; owns the architectural HI and LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Drives a busy flag that the hazard unit ORs into its stall logic, so stall_fetch, stall_decode and flush_execute_register hold the pipeline while an operation is in flight.
- HI/LO outputs feed the execute-stage operand path used by MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO register width. Iteration count equals WIDTH.

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  asynchronous, active-high reset.
- operation_execute  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none.
- source_A_execute  input  WIDTH  Rs operand (dividend / multiplicand / MTHI/MTLO data).
- source_B_execute  input  WIDTH  Rt operand (divisor / multiplier).
- flush_execute_register  input  1  from hazard unit; the current execute-stage instruction is squashed.
- busy  output  1  operation in flight; the hazard unit stalls on it.
- HI_output  output  WIDTH  architectural HI.
- LO_output  output  WIDTH  architectural LO.
- done_pulse  output  1  one-cycle pulse on the cycle HI/LO update from MULT/DIV.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - State goes to IDLE; HI=0, LO=0, busy=0, done_pulse=0.
  - Internal accumulator, counter and sign flags are cleared. An in-flight operation is discarded.
- States: IDLE, MULTIPLY, DIVIDE, FIXUP.
- IDLE, operation accepted on a rising edge when state=IDLE, operation is 001–110, and flush_execute_register=0.
  - With flush_execute_register=1, no state change and no HI/LO write.
- MTHI/MTLO:
  - Write source_A_execute into HI (or LO) at the accepting edge.
  - busy never asserts. The other register is unchanged.
- MULT/MULTU, at acceptance:
  - Latch |A| and |B|; take magnitudes only for MULT.
  - Record result sign = A[WIDTH-1] XOR B[WIDTH-1] (MULT only).
  - Clear the 2*WIDTH accumulator, counter := 0, go to MULTIPLY, busy=1 from the next cycle.
- MULTIPLY, one shift-add step per cycle (LSB-first multiplier):
  - After WIDTH steps go to FIXUP.
- DIV/DIVU, at acceptance:
  - Latch magnitudes (DIV) or raw values (DIVU).
  - Quotient sign = A sign XOR B sign; remainder sign = A sign.
  - Go to DIVIDE.
  - Divisor == 0: skip iteration and go straight to FIXUP with LO := all ones and HI := source_A_execute (raw, both variants).
- DIVIDE, one restoring shift-subtract step per cycle:
  - After WIDTH steps go to FIXUP.
- FIXUP:
  - Apply two's-complement negation where the recorded sign is set (signed ops only).
  - MULT/MULTU: HI = product[2W-1:W], LO = product[W-1:0].
  - DIV/DIVU: LO = quotient, HI = remainder.
  - Write HI/LO at the FIXUP edge, done_pulse=1 for that cycle, return to IDLE; busy drops in the same cycle as done_pulse.
- Latency:
  - Accepted at edge E0. busy=1 during cycles E0..E(WIDTH+1).
  - HI/LO are visible after edge E(WIDTH+1), which is 33 edges for WIDTH=32.
  - Divide-by-zero is accepted at E0 and visible after E1.
- Boundary cases:
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (truncated wrap, no trap).
  - Any operation, MTHI or MTLO presented while busy=1 is ignored. The hazard unit guarantees this cannot occur; the unit must still not corrupt state.
  - flush_execute_register has no effect once an operation is accepted; an in-flight op always completes.
  - HI/LO change only at MTHI/MTLO acceptance or the FIXUP edge.

Test Plan:
- Reset, then MULT A=0xFFFFFFFD (−3), B=5 → busy high 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1, single done_pulse.
- MULTU A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Then DIVU 100/7 → LO=14, HI=2.
- DIV A=−7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / −1 → LO=0x80000000, HI=0.
- DIVU A=0x1234, B=0 → busy for 1 cycle, LO=0xFFFFFFFF, HI=0x1234.
- MTHI 0xAAAA0000 with flush_execute_register=1 → HI unchanged. Without flush → HI=0xAAAA0000, busy stays 0. MTLO during MULTIPLY → LO unchanged until FIXUP result.
- MULT started, reset pulsed asynchronously at cycle 10 (off-edge) → immediately busy=0, HI=LO=0. A subsequent MULT 6*7 → LO=42, HI=0.
